sequenciador_servo: RTL and testbench

Rate-limited position sequencer for one hobby servo. Accepts a target pulse width through a start handshake and ramps its `largura` output toward that target in fixed increments, one increment per step period, so the servo never jumps. `largura` drives the `largura` input of the team's PWM generator (50 Hz frame, 50 MHz clock). The block reports completion with a one-cycle `pronto` pulse.

---
 rtl/sequenciador_servo.sv | 168 ++++++++++++++++
 tb/tb_sequenciador_servo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_servo.sv
// sequenciador_servo
// Rate-limited position sequencer for a single hobby servo. A target pulse
// width is accepted through a start request and `largura` is ramped toward
// it by at most PASSO counts once every PERIODO_PASSO+1 clock cycles, so the
// servo never jumps. `largura` feeds the PWM generator's width input.
//
// Ports:
//   clock      - system clock, all state changes on the rising edge
//   reset      - asynchronous, active-low reset
//   iniciar    - start request, only looked at while idle
//   alvo       - target width, captured together with an accepted iniciar
//   parar      - abort request, honoured while a move is in progress
//   largura    - current commanded width (registered)
//   ocupado    - a move is in progress
//   pronto     - one-cycle pulse when the target has been reached
//   saturado   - the latched target was clamped into [MIN, MAX]
//   estado_dbg - current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where iniciar=1 and the
// block is idle (ocupado=0, pronto=0). Requests in any other cycle are
// dropped, not queued. ocupado and pronto come straight from the state
// register, so they have no combinational path from any input.
module sequenciador_servo #(
  parameter int LARGURA_MIN   = 50000,
  parameter int LARGURA_MAX   = 100000,
  parameter int PASSO         = 500,
  parameter int PERIODO_PASSO = 1000000,
  parameter int W             = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic [W-1:0] alvo,
  input  logic         parar,
  output logic [W-1:0] largura,
  output logic         ocupado,
  output logic         pronto,
  output logic         saturado,
  output logic [2:0]   estado_dbg
);

  typedef enum logic [2:0] {
    ST_OCIOSO  = 3'd0,
    ST_CARREGA = 3'd1,
    ST_ESPERA  = 3'd2,
    ST_PASSO   = 3'd3,
    ST_FIM     = 3'd4
  } estado_t;

  // The counter only has to reach PERIODO_PASSO-1.
  localparam int CW = (PERIODO_PASSO > 1) ? $clog2(PERIODO_PASSO) : 1;
  localparam logic [CW-1:0] CNT_ULT  = CW'(PERIODO_PASSO - 1);
  localparam logic [W-1:0]  L_MIN    = W'(LARGURA_MIN);
  localparam logic [W-1:0]  L_MAX    = W'(LARGURA_MAX);
  localparam logic [W-1:0]  L_CENTRO = W'((LARGURA_MIN + LARGURA_MAX) / 2);
  localparam logic [W:0]    PASSO_X  = (W+1)'(PASSO);
  localparam logic [W-1:0]  PASSO_N  = W'(PASSO);

  estado_t       r_estado;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_alvo;
  logic [W-1:0]  r_largura;
  logic          r_saturado;

  estado_t       w_prox_estado;
  logic [CW-1:0] w_prox_cnt;
  logic [W-1:0]  w_prox_alvo;
  logic [W-1:0]  w_prox_largura;
  logic          w_prox_saturado;

  logic          w_subindo;
  logic [W:0]    w_dist;

  // Distance to the target in W+1 bits so the subtraction cannot wrap.
  assign w_subindo = (r_alvo > r_largura);
  assign w_dist    = w_subindo ? ({1'b0, r_alvo} - {1'b0, r_largura})
                               : ({1'b0, r_largura} - {1'b0, r_alvo});

  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_cnt      = r_cnt;
    w_prox_alvo     = r_alvo;
    w_prox_largura  = r_largura;
    w_prox_saturado = r_saturado;
    unique case (r_estado)
      ST_OCIOSO: begin
        if (iniciar) begin
          if (alvo < L_MIN) begin
            w_prox_alvo     = L_MIN;
            w_prox_saturado = 1'b1;
          end else if (alvo > L_MAX) begin
            w_prox_alvo     = L_MAX;
            w_prox_saturado = 1'b1;
          end else begin
            w_prox_alvo     = alvo;
            w_prox_saturado = 1'b0;
          end
          w_prox_estado = ST_CARREGA;
        end
      end
      ST_CARREGA: begin
        if (parar) begin
          w_prox_estado = ST_OCIOSO;
        end else if (r_alvo == r_largura) begin
          w_prox_estado = ST_FIM;
        end else begin
          w_prox_cnt    = '0;
          w_prox_estado = ST_ESPERA;
        end
      end
      ST_ESPERA: begin
        if (parar) begin
          w_prox_estado = ST_OCIOSO;
        end else if (r_cnt == CNT_ULT) begin
          w_prox_estado = ST_PASSO;
        end else begin
          w_prox_cnt = r_cnt + 1'b1;
        end
      end
      ST_PASSO: begin
        // Abort wins over the width update in this cycle.
        if (parar) begin
          w_prox_estado = ST_OCIOSO;
        end else if (w_dist <= PASSO_X) begin
          w_prox_largura = r_alvo;
          w_prox_estado  = ST_FIM;
        end else begin
          // dist > PASSO, so a full step stays strictly short of the target
          // and therefore inside [MIN, MAX] with no overflow.
          w_prox_largura = w_subindo ? (r_largura + PASSO_N)
                                     : (r_largura - PASSO_N);
          w_prox_cnt     = '0;
          w_prox_estado  = ST_ESPERA;
        end
      end
      ST_FIM: begin
        w_prox_estado = ST_OCIOSO;
      end
      default: begin
        w_prox_estado = ST_OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= ST_OCIOSO;
      r_cnt      <= '0;
      r_alvo     <= L_CENTRO;
      r_largura  <= L_CENTRO;
      r_saturado <= 1'b0;
    end else begin
      r_estado   <= w_prox_estado;
      r_cnt      <= w_prox_cnt;
      r_alvo     <= w_prox_alvo;
      r_largura  <= w_prox_largura;
      r_saturado <= w_prox_saturado;
    end
  end

  assign largura    = r_largura;
  assign saturado   = r_saturado;
  assign pronto     = (r_estado == ST_FIM);
  assign ocupado    = (r_estado == ST_CARREGA) || (r_estado == ST_ESPERA) ||
                      (r_estado == ST_PASSO);
  assign estado_dbg = r_estado;

endmodule

// File: tb/tb_sequenciador_servo.sv
// Testbench for sequenciador_servo with MIN=100, MAX=200, PASSO=10,
// PERIODO_PASSO=4, W=8. A cycle-count model predicts largura, ocupado,
// pronto and saturado on every cycle; directed literal checks pin the model.
module tb_sequenciador_servo;

  localparam int MIN = 100;
  localparam int MAX = 200;
  localparam int PAS = 10;
  localparam int PER = 4;
  localparam int W   = 8;
  localparam int CEN = (MIN + MAX) / 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         iniciar = 1'b0;
  logic [W-1:0] alvo = '0;
  logic         parar = 1'b0;
  logic [W-1:0] largura;
  logic         ocupado;
  logic         pronto;
  logic         saturado;
  logic [2:0]   estado_dbg;

  sequenciador_servo #(
    .LARGURA_MIN(MIN), .LARGURA_MAX(MAX), .PASSO(PAS),
    .PERIODO_PASSO(PER), .W(W)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .alvo(alvo),
    .parar(parar), .largura(largura), .ocupado(ocupado), .pronto(pronto),
    .saturado(saturado), .estado_dbg(estado_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int ciclo = 0;

  task automatic chk(input string nome, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nome, ciclo, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A move is described by its start width, clamped target and the number
  // of cycles since the accepting edge (cycle 1 = first cycle after it).
  int m_l0 = CEN, m_t = CEN, m_l_idle = CEN, m_c = 0, m_n = 0, m_pc = 0;
  bit m_run = 1'b0, m_sat = 1'b0;

  function automatic int exp_l(input int c);
    int d, s, mv;
    d  = (m_t >= m_l0) ? (m_t - m_l0) : (m_l0 - m_t);
    s  = (c >= 2) ? (c - 2) / (PER + 1) : 0;
    if (s > m_n) s = m_n;
    mv = s * PAS;
    if (mv > d) mv = d;
    return (m_t >= m_l0) ? (m_l0 + mv) : (m_l0 - mv);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      if (m_run) begin
        if (m_c == m_pc) begin
          m_run    = 1'b0;
          m_l_idle = m_t;
        end else if (parar) begin
          m_run    = 1'b0;
          m_l_idle = exp_l(m_c);
        end else begin
          m_c++;
        end
      end else if (iniciar) begin
        int a, d;
        a = int'(alvo);
        m_sat = (a < MIN) || (a > MAX);
        m_t   = (a < MIN) ? MIN : ((a > MAX) ? MAX : a);
        m_l0  = m_l_idle;
        d     = (m_t >= m_l0) ? (m_t - m_l0) : (m_l0 - m_t);
        m_n   = (d + PAS - 1) / PAS;
        m_pc  = m_n * (PER + 1) + 2;
        m_c   = 1;
        m_run = 1'b1;
      end
    end
  end

  always @(negedge reset) begin
    m_run    = 1'b0;
    m_l_idle = CEN;
    m_sat    = 1'b0;
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      int el, eo, ep;
      el = m_run ? exp_l(m_c) : m_l_idle;
      eo = (m_run && m_c < m_pc) ? 1 : 0;
      ep = (m_run && m_c == m_pc) ? 1 : 0;
      chk("mdl_largura", int'(largura), el);
      chk("mdl_ocupado", int'(ocupado), eo);
      chk("mdl_pronto", int'(pronto), ep);
      chk("mdl_saturado", int'(saturado), int'(m_sat));
    end
  end

  // ---------------- driver tasks ----------------
  // Drive a start request; returns at the negedge of cycle 1.
  task automatic iniciar_mov(input int a);
    iniciar = 1'b1;
    alvo    = W'(a);
    @(negedge clock);
    iniciar = 1'b0;
    ciclo   = 1;
  endtask

  task automatic avanca_ate(input int k);
    while (ciclo < k) begin
      @(negedge clock);
      ciclo++;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_largura", int'(largura), 150);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_saturado", int'(saturado), 0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // 1: parar while idle does nothing
    for (int i = 0; i < 3; i++) begin
      parar = 1'b1;
      @(negedge clock);
      parar = 1'b0;
      @(negedge clock);
    end
    chk("t1_largura", int'(largura), 150);
    chk("t1_ocupado", int'(ocupado), 0);

    // 2: 150 -> 180
    iniciar_mov(180);
    chk("t2_ocup_c1", int'(ocupado), 1);
    avanca_ate(6);  chk("t2_c6", int'(largura), 150);
    avanca_ate(7);  chk("t2_c7", int'(largura), 160);
    avanca_ate(12); chk("t2_c12", int'(largura), 170);
    avanca_ate(16); chk("t2_pronto_c16", int'(pronto), 0);
    chk("t2_ocup_c16", int'(ocupado), 1);
    avanca_ate(17); chk("t2_c17", int'(largura), 180);
    chk("t2_pronto_c17", int'(pronto), 1);
    chk("t2_ocup_c17", int'(ocupado), 0);
    avanca_ate(19);

    // 3: 180 -> 125, non-multiple distance
    iniciar_mov(125);
    avanca_ate(7);  chk("t3_c7", int'(largura), 170);
    avanca_ate(27); chk("t3_c27", int'(largura), 130);
    avanca_ate(32); chk("t3_fim", int'(largura), 125);
    chk("t3_pronto", int'(pronto), 1);
    chk("t3_sat", int'(saturado), 0);
    avanca_ate(34);

    // 4: clamping and zero move
    iniciar_mov(250);
    chk("t4_sat_hi", int'(saturado), 1);
    avanca_ate(42); chk("t4_fim_hi", int'(largura), 200);
    chk("t4_pronto_hi", int'(pronto), 1);
    avanca_ate(44);
    iniciar_mov(20);
    avanca_ate(52); chk("t4_fim_lo", int'(largura), 100);
    chk("t4_sat_lo", int'(saturado), 1);
    avanca_ate(54);
    iniciar_mov(150);
    avanca_ate(27); chk("t4_to150", int'(largura), 150);
    chk("t4_sat_ok", int'(saturado), 0);
    avanca_ate(29);
    iniciar_mov(150);
    chk("t4_zero_c1", int'(pronto), 0);
    avanca_ate(2);  chk("t4_zero_c2", int'(pronto), 1);
    chk("t4_zero_larg", int'(largura), 150);
    avanca_ate(4);

    // 5: abort on the PASSO cycle of the second step
    iniciar_mov(200);
    avanca_ate(11);
    parar = 1'b1;
    chk("t5_c11", int'(largura), 160);
    avanca_ate(12);
    parar = 1'b0;
    chk("t5_ocup", int'(ocupado), 0);
    chk("t5_larg", int'(largura), 160);
    chk("t5_pronto", int'(pronto), 0);
    avanca_ate(20);
    iniciar_mov(200);
    avanca_ate(7);  chk("t5_resume", int'(largura), 170);
    avanca_ate(22); chk("t5_fim", int'(largura), 200);
    chk("t5_pronto_fim", int'(pronto), 1);
    avanca_ate(24);

    // 6: ignored start mid-ramp, then async reset mid-ramp
    iniciar_mov(120);
    avanca_ate(9);
    iniciar = 1'b1;
    alvo    = W'(100);
    avanca_ate(10);
    iniciar = 1'b0;
    avanca_ate(42); chk("t6_fim", int'(largura), 120);
    chk("t6_pronto", int'(pronto), 1);
    avanca_ate(44);
    iniciar_mov(180);
    avanca_ate(10);
    chk("t6_mid", int'(largura), 130);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_larg", int'(largura), 150);
    chk("t6_rst_ocup", int'(ocupado), 0);
    chk("t6_rst_pronto", int'(pronto), 0);
    avanca_ate(12);
    reset = 1'b1;
    avanca_ate(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net: the directed sequence is fixed-length, this only trips on a
  // broken bench or simulator.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
